// File: rtl/panel_pkg.sv
// Shared panel geometry, scan-state encoding and the frame bit-index helper.
package panel_pkg;
  localparam int ROWS = 5;
  localparam int COLS = 7;
  localparam int FW   = ROWS * COLS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_DRIVE
  } scan_state_e;

  // Frame bit for row r, column c.
  function automatic int idx(input int r, input int c);
    return r * COLS + c;
  endfunction
endpackage

// File: rtl/matrix_scan_driver_if.sv
// Frame handshake plus panel outputs of the matrix scan driver.
interface matrix_scan_driver_if;
  import panel_pkg::*;

  logic            enable;
  logic [FW-1:0]   frame_data;
  logic            frame_valid;
  logic            frame_ready;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic            frame_sync;

  modport master (
    output enable, frame_data, frame_valid,
    input  frame_ready, row, col, frame_sync
  );

  modport slave (
    input  enable, frame_data, frame_valid,
    output frame_ready, row, col, frame_sync
  );
endinterface

// File: rtl/frame_double_buffer.sv
// Shadow/active frame pair: the producer fills the shadow, the scanner swaps it
// into the active buffer only at scan boundaries so frames never tear.
module frame_double_buffer
  import panel_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [FW-1:0] frame_data_i,
  input  logic          frame_valid_i,
  output logic          frame_ready_o,
  input  logic          swap_i,
  output logic          shadow_full_o,
  output logic [FW-1:0] active_o
);
  logic [FW-1:0] shadow_q, shadow_d;
  logic [FW-1:0] active_q, active_d;
  logic          full_q, full_d;
  logic          ready_q;
  logic          accept;
  logic          swap;

  // Accept and swap are mutually exclusive: accept needs an empty shadow,
  // swap needs a full one.
  always_comb begin
    accept   = frame_valid_i & ready_q;
    swap     = swap_i & full_q;
    shadow_d = accept ? frame_data_i : shadow_q;
    active_d = swap ? shadow_q : active_q;
    full_d   = accept | (full_q & ~swap);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      full_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      full_q   <= full_d;
      ready_q  <= ~full_d;
    end
  end

  assign frame_ready_o = ready_q;
  assign shadow_full_o = full_q;
  assign active_o      = active_q;
endmodule

// File: rtl/matrix_scan_driver.sv
// Column-multiplexed 5x7 LED matrix scanner with blanking between columns
// and a double-buffered frame input.
module matrix_scan_driver
  import panel_pkg::*;
#(
  parameter int DWELL = 5000,
  parameter int BLANK = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_scan_driver_if.slave  bus
);
  localparam int TMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int IW   = $clog2(COLS);

  scan_state_e     state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [ROWS-1:0] row_q, row_d;
  logic [COLS-1:0] col_q, col_d;
  logic            sync_q, sync_d;
  logic            swap;
  logic            shadow_full;
  logic [FW-1:0]   active;

  frame_double_buffer u_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_data_i  (bus.frame_data),
    .frame_valid_i (bus.frame_valid),
    .frame_ready_o (bus.frame_ready),
    .swap_i        (swap),
    .shadow_full_o (shadow_full),
    .active_o      (active)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    sync_d  = 1'b0;
    swap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        swap = 1'b1;
        if (bus.enable) begin
          state_d = ST_BLANK;
          idx_d   = '0;
          timer_d = '0;
          sync_d  = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (timer_q == TW'(BLANK - 1)) begin
          state_d = ST_DRIVE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (timer_q == TW'(DWELL - 1)) begin
          state_d = ST_BLANK;
          timer_d = '0;
          // Last column: the scan wraps, which is the only safe point to
          // bring a pending frame onto the display.
          if (idx_q == IW'(COLS - 1)) begin
            idx_d  = '0;
            swap   = 1'b1;
            sync_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    row_d = '0;
    col_d = '0;
    if (state_d == ST_DRIVE) begin
      col_d = COLS'(1) << idx_d;
      for (int r = 0; r < ROWS; r++) begin
        row_d[r] = active[idx(r, int'(idx_d))];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sync_q  <= sync_d;
    end
  end

  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.frame_sync = sync_q;
endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench: a cycle-position model of the scan predicts every output cycle.
module tb_matrix_scan_driver;
  import panel_pkg::*;

  localparam int DW  = 4;
  localparam int BL  = 1;
  localparam int SEG = DW + BL;
  localparam int PER = COLS * SEG;

  typedef struct {
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;
    logic            sync;
    logic            rdy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_scan_driver_if bus();

  matrix_scan_driver #(.DWELL(DW), .BLANK(BL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t          expq[$];
  logic [FW-1:0] pend[$];
  int            nvec = 0;
  int            nfail = 0;

  // Reference model: position t within the scan, frames as plain buffers.
  bit            run = 0;
  int            t = 0;
  logic [FW-1:0] m_act = '0;
  logic [FW-1:0] m_sh = '0;
  bit            m_full = 0;
  bit            m_rdy = 1;
  bit            took = 0;

  always @(posedge clk) begin
    exp_t e;
    bit   acc;
    bit   swp;
    int   c;
    took = 0;
    if (!rst_n) begin
      run = 0; t = 0; m_act = '0; m_sh = '0; m_full = 0; m_rdy = 1;
    end else begin
      acc = bus.frame_valid && m_rdy;
      swp = 0;
      if (!run) begin
        swp = m_full;
        if (bus.enable) begin run = 1; t = 0; end
      end else if (!bus.enable) begin
        run = 0;
      end else begin
        t++;
        if (t == PER) begin t = 0; swp = m_full; end
      end
      if (swp) begin m_act = m_sh; m_full = 0; end
      if (acc) begin m_sh = bus.frame_data; m_full = 1; took = 1; end
      m_rdy = !m_full;
    end
    e.row = '0; e.col = '0; e.sync = 1'b0; e.rdy = m_rdy;
    if (run) begin
      c = t / SEG;
      e.sync = (t == 0);
      if ((t % SEG) >= BL) begin
        e.col = COLS'(1) << c;
        for (int r = 0; r < ROWS; r++) e.row[r] = m_act[r * COLS + c];
      end
    end
    expq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() == 0) begin
      nfail++;
      $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
    end else begin
      e = expq.pop_front();
      nvec++;
      if (bus.row !== e.row || bus.col !== e.col || bus.frame_sync !== e.sync ||
          bus.frame_ready !== e.rdy) begin
        nfail++;
        $display("FAIL outputs at %0t: row=%b exp %b col=%b exp %b sync=%b exp %b ready=%b exp %b",
                 $time, bus.row, e.row, bus.col, e.col, bus.frame_sync, e.sync,
                 bus.frame_ready, e.rdy);
      end
    end
  end

  // One cycle of stimulus: retire an accepted frame, then offer the next one.
  task automatic cyc();
    @(negedge clk);
    if (took && pend.size() > 0) void'(pend.pop_front());
    bus.frame_valid = (pend.size() > 0);
    bus.frame_data  = (pend.size() > 0) ? pend[0] : '0;
  endtask

  task automatic bound_fail(input string what);
    nfail++;
    $display("FAIL wait_%s at %0t: condition not reached, required within bound", what, $time);
  endtask

  logic [FW-1:0] f;
  int            k;

  initial begin
    bus.enable = 1'b0;
    bus.frame_valid = 1'b0;
    bus.frame_data = '0;
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;

    // Blank scan with no frame loaded.
    bus.enable = 1'b1;
    repeat (2 * PER + 3) cyc();
    bus.enable = 1'b0;
    repeat (2) cyc();

    // Single pixel loaded while idle.
    f = '0;
    f[idx(2, 3)] = 1'b1;
    pend.push_back(f);
    repeat (4) cyc();
    bus.enable = 1'b1;
    repeat (PER + 5) cyc();

    // Two frames back to back, offered at cycle 10 of a scan.
    for (k = 0; k < 200 && !(run && t == 9); k++) cyc();
    if (!(run && t == 9)) bound_fail("scan10");
    pend.push_back(FW'({$urandom(), $urandom()}));
    pend.push_back(FW'({$urandom(), $urandom()}));
    repeat (3 * PER + 5) cyc();

    // Accept landing exactly on the wrap edge with an empty shadow.
    for (k = 0; k < 300 && !(run && t == PER - 2 && !m_full && pend.size() == 0); k++) cyc();
    if (!(run && t == PER - 2)) bound_fail("prewrap");
    pend.push_back(FW'({$urandom(), $urandom()}));
    repeat (3 * PER + 2) cyc();

    // Drop enable during DRIVE of column 4, then resume.
    for (k = 0; k < 200 && !(run && t == 4 * SEG + BL + 1); k++) cyc();
    if (!(run && t == 4 * SEG + BL + 1)) bound_fail("col4");
    bus.enable = 1'b0;
    repeat (5) cyc();
    bus.enable = 1'b1;
    repeat (PER + 3) cyc();

    // Reset pulse mid-DRIVE while the shadow holds a frame.
    pend.push_back(FW'({$urandom(), $urandom()}));
    for (k = 0; k < 200 && !(run && m_full && pend.size() == 0 && (t % SEG) >= BL); k++) cyc();
    if (!(run && m_full)) bound_fail("shadowfull");
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    repeat (PER + 5) cyc();

    // Randomized traffic, enable toggles and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0 && pend.size() < 3)
        pend.push_back(FW'({$urandom(), $urandom()}));
      if ($urandom_range(0, 149) == 0) bus.enable = ~bus.enable;
      rst_n = ($urandom_range(0, 499) != 0);
      cyc();
    end
    rst_n = 1'b1;
    repeat (3) cyc();
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
